// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit counter direction predictor with tagged BTB
//
// Registers one prediction per fetch: the counter table gives the direction and
// the BTB the target. Resolved conditional branches train both tables.
//
// Parameters:
//   XLEN     PC width
//   ENTRIES  table entries (power of two, >= 4)
//   PC_INIT  reset value of pred_pc_o (defaults to the PC_INIT macro)
//
// Ports:
//   clock_i               rising-edge clock
//   reset_i               synchronous active-high reset
//   stall_i               hold prediction outputs
//   flush_i               kill pending prediction (beats stall and fetch)
//   fetch_valid_i         fetch_pc_i is a real fetch
//   fetch_pc_i            PC being fetched
//   pred_valid_o          prediction outputs valid
//   pred_taken_o          predicted taken
//   pred_pc_o             predicted next PC
//   resolve_valid_i       a conditional branch resolved this cycle
//   resolve_pc_i          PC of the resolved branch
//   resolve_taken_i       actual outcome
//   resolve_target_i      actual taken target
//   resolve_pred_taken_i  prediction that travelled with the branch
//   branch_cnt_o          resolved-branch count (statistics build only)
//   mispredict_cnt_o      mispredict count (statistics build only)
//
// Macro BPU_STATS_EN: when defined, builds saturating statistics counters;
// otherwise both counter outputs are tied to zero.

`ifndef PC_INIT
`define PC_INIT '0
`endif

module branch_predictor #(
    parameter int              XLEN    = 32,
    parameter int              ENTRIES = 64,
    parameter logic [XLEN-1:0] PC_INIT = `PC_INIT
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o,
    input  logic            resolve_valid_i,
    input  logic [XLEN-1:0] resolve_pc_i,
    input  logic            resolve_taken_i,
    input  logic [XLEN-1:0] resolve_target_i,
    input  logic            resolve_pred_taken_i,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispredict_cnt_o
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    // Table storage. Only valid and ctr are reset; tag and target are
    // meaningless while valid is low.
    logic            valid_q  [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IDX-1:0]  fetch_idx;
    logic [TAGW-1:0] fetch_tag;
    logic            fetch_hit;
    logic            fetch_taken;
    logic [XLEN-1:0] fetch_seq_pc;
    logic [XLEN-1:0] fetch_next_pc;

    assign fetch_idx = fetch_pc_i[IDX+1:2];
    assign fetch_tag = fetch_pc_i[XLEN-1:IDX+2];

    // The table is read combinationally from the registered arrays, so a
    // same-cycle update to the same index is not visible here (read-old).
    always_comb begin
        fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        fetch_taken   = fetch_valid_i && fetch_hit && ctr_q[fetch_idx][1];
        fetch_seq_pc  = fetch_pc_i + XLEN'(4);
        fetch_next_pc = fetch_seq_pc;
        if (fetch_taken) begin
            fetch_next_pc = target_q[fetch_idx];
        end
    end

    // ------------------------------------------------------------------
    // Prediction output register
    // ------------------------------------------------------------------
    // On flush the PC is left alone: the prediction it belongs to is dead.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_pc_o    <= PC_INIT;
        end else if (flush_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
        end else if (!stall_i) begin
            pred_valid_o <= fetch_valid_i;
            pred_taken_o <= fetch_taken;
            pred_pc_o    <= fetch_next_pc;
        end
    end

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    logic [IDX-1:0]  res_idx;
    logic [TAGW-1:0] res_tag;
    logic            res_hit;
    logic [1:0]      res_ctr;
    logic [1:0]      res_ctr_next;
    logic            res_write_ctr;
    logic            res_write_btb;

    assign res_idx = resolve_pc_i[IDX+1:2];
    assign res_tag = resolve_pc_i[XLEN-1:IDX+2];

    always_comb begin
        res_hit       = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        res_ctr       = ctr_q[res_idx];
        res_ctr_next  = res_ctr;
        res_write_ctr = 1'b0;
        res_write_btb = 1'b0;
        if (resolve_valid_i) begin
            if (res_hit) begin
                res_write_ctr = 1'b1;
                res_write_btb = resolve_taken_i;
                if (resolve_taken_i) begin
                    res_ctr_next = (res_ctr == 2'b11) ? 2'b11 : res_ctr + 2'b01;
                end else begin
                    res_ctr_next = (res_ctr == 2'b00) ? 2'b00 : res_ctr - 2'b01;
                end
            end else if (resolve_taken_i) begin
                // Allocate weakly taken so one contrary outcome flips it.
                res_write_ctr = 1'b1;
                res_write_btb = 1'b1;
                res_ctr_next  = 2'b10;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (res_write_ctr) begin
            valid_q[res_idx] <= 1'b1;
            ctr_q[res_idx]   <= res_ctr_next;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && res_write_btb) begin
            tag_q[res_idx]    <= res_tag;
            target_q[res_idx] <= resolve_target_i;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BPU_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (resolve_valid_i) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if ((resolve_taken_i != resolve_pred_taken_i) &&
                (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

    // Instruction-alignment bits never index the table; the travelling
    // prediction only feeds the statistics build.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i[1:0], resolve_pc_i[1:0], resolve_pred_taken_i};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor against a table model
module tb_branch_predictor;

    localparam int          ENTRIES = 64;
    localparam int          IDX     = 6;
    localparam logic [31:0] PC_RST  = 32'h0000_1000;

    logic        clock_i = 1'b0;
    logic        reset_i, stall_i, flush_i, fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic        resolve_valid_i, resolve_taken_i, resolve_pred_taken_i;
    logic [31:0] resolve_pc_i, resolve_target_i;
    logic        pred_valid_o, pred_taken_o;
    logic [31:0] pred_pc_o, branch_cnt_o, mispredict_cnt_o;

    always #5 clock_i = ~clock_i;

    branch_predictor #(
        .XLEN    (32),
        .ENTRIES (ENTRIES),
        .PC_INIT (PC_RST)
    ) dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .stall_i              (stall_i),
        .flush_i              (flush_i),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_pc_i           (fetch_pc_i),
        .pred_valid_o         (pred_valid_o),
        .pred_taken_o         (pred_taken_o),
        .pred_pc_o            (pred_pc_o),
        .resolve_valid_i      (resolve_valid_i),
        .resolve_pc_i         (resolve_pc_i),
        .resolve_taken_i      (resolve_taken_i),
        .resolve_target_i     (resolve_target_i),
        .resolve_pred_taken_i (resolve_pred_taken_i),
        .branch_cnt_o         (branch_cnt_o),
        .mispredict_cnt_o     (mispredict_cnt_o)
    );

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid  [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    bit          m_pv, m_pt, m_pc_known;
    logic [31:0] m_pc;
    longint      m_bc, m_mc;

    typedef struct {
        logic        v;
        logic        t;
        logic [31:0] pc;
        bit          pc_chk;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_cyc  = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (output cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic cycle(input bit rst, input bit st, input bit fl, input bit fv,
                         input logic [31:0] fpc, input bit rv, input logic [31:0] rpc,
                         input bit rt, input logic [31:0] rtgt, input bit rpt);
        int   fi, ri;
        bit   hit, tk;
        exp_t e;
        reset_i = rst; stall_i = st; flush_i = fl;
        fetch_valid_i = fv; fetch_pc_i = fpc;
        resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
        resolve_target_i = rtgt; resolve_pred_taken_i = rpt;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 0;
            end
            m_pv = 0; m_pt = 0; m_pc = PC_RST; m_pc_known = 1;
            m_bc = 0; m_mc = 0;
        end else begin
            fi  = slot_of(fpc);
            hit = m_valid[fi] && (m_tag[fi] == (fpc >> (IDX + 2)));
            tk  = hit && (m_ctr[fi] >= 2);
            if (fl) begin
                m_pv = 0; m_pt = 0; m_pc_known = 0;
            end else if (!st) begin
                m_pv = fv;
                m_pt = fv && tk;
                m_pc = m_pt ? m_target[fi] : fpc + 32'd4;
                m_pc_known = 1;
            end
            if (rv) begin
                ri  = slot_of(rpc);
                hit = m_valid[ri] && (m_tag[ri] == (rpc >> (IDX + 2)));
                if (hit) begin
                    if (rt) begin
                        m_ctr[ri]    = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
                        m_target[ri] = rtgt;
                    end else begin
                        m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
                    end
                end else if (rt) begin
                    m_valid[ri]  = 1;
                    m_tag[ri]    = rpc >> (IDX + 2);
                    m_target[ri] = rtgt;
                    m_ctr[ri]    = 2;
                end
                if (m_bc < 64'hFFFF_FFFF) m_bc++;
                if (rt != rpt && m_mc < 64'hFFFF_FFFF) m_mc++;
            end
        end
        e.v = m_pv; e.t = m_pt; e.pc = m_pc; e.pc_chk = m_pc_known;
`ifdef BPU_STATS_EN
        e.bc = m_bc[31:0]; e.mc = m_mc[31:0];
`else
        e.bc = 32'd0; e.mc = 32'd0;
`endif
        sb.push_back(e);
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        cycle(0, 0, 0, 1, pc, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit pt);
        cycle(0, 0, 0, 0, 32'h0, 1, pc, t, tgt, pt);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 31) == 0) begin
            pc = 32'hFFFF_FFFC;
        end else begin
            pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
        end
        return pc;
    endfunction

    // Monitor: one expected record per clock, compared away from the edge.
    always @(negedge clock_i) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            mon_cyc++;
            check("pred_valid", mon_cyc, {31'b0, pred_valid_o}, {31'b0, e.v});
            check("pred_taken", mon_cyc, {31'b0, pred_taken_o}, {31'b0, e.t});
            if (e.pc_chk) check("pred_pc", mon_cyc, pred_pc_o, e.pc);
            check("branch_cnt", mon_cyc, branch_cnt_o, e.bc);
            check("mispredict_cnt", mon_cyc, mispredict_cnt_o, e.mc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        do_reset();
        // Cold lookup, then allocate and hit.
        fetch(32'h100);
        resolve(32'h100, 1, 32'h80, 0);
        fetch(32'h100);
        resolve(32'h100, 0, 32'h0, 1);
        resolve(32'h100, 0, 32'h0, 1);
        fetch(32'h100);
        for (int i = 0; i < 4; i++) resolve(32'h100, 1, 32'h80, 0);
        resolve(32'h100, 0, 32'h0, 1);
        fetch(32'h100);
        // Alias: same index, different tag.
        fetch(32'h200);
        // Read-old on same-cycle resolve and fetch.
        do_reset();
        cycle(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 32'h80, 0);
        fetch(32'h100);
        // Stall with changing fetch PC, then flush with stall, then wrap.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 32'h40 + 32'(i * 4), 0, 32'h0, 0, 32'h0, 0);
        cycle(0, 1, 1, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
        fetch(32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 32'h300, 0, 32'h0, 0, 32'h0, 0);
        // Statistics: five resolves, two mispredicted, then reset.
        do_reset();
        resolve(32'h10, 1, 32'h400, 1);
        resolve(32'h14, 0, 32'h0, 1);
        resolve(32'h18, 1, 32'h500, 0);
        resolve(32'h1C, 0, 32'h0, 0);
        resolve(32'h10, 1, 32'h400, 1);
        fetch(32'h10);
        do_reset();
        // Randomized traffic over a small PC space so hits and aliases occur.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 10) == 0, $urandom_range(0, 3) != 0, rand_pc(),
                  $urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
        end
        cycle(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        repeat (3) @(negedge clock_i);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
